hilo_muldiv_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 36 +++
 rtl/hilo_divider_core.sv | 48 ++++
 rtl/hilo_muldiv_unit.sv | 211 +++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control encoding, HI/LO engine states and
// result constants used by the ALU and the multiply/divide unit.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ITER_W = 5;

  // Index of the final shift-add / restoring iteration.
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(XLEN - 1);

  // Quotient produced by a divide by zero.
  localparam logic [XLEN-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  // ALU control codes that address the HI/LO engine.
  typedef enum logic [4:0] {
    CTRL_MULT  = 5'b10000,
    CTRL_MULTU = 5'b10001,
    CTRL_DIV   = 5'b10010,
    CTRL_DIVU  = 5'b10011,
    CTRL_MTLO  = 5'b10101,
    CTRL_MTHI  = 5'b10110
  } control_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } hilo_state_t;

  // Magnitude of a value when it is treated as signed, raw value otherwise.
  function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/hilo_divider_core.sv
// Restoring divider datapath: one quotient bit per enabled step, MSB first.
// The step count is owned by the instantiating FSM.
module hilo_divider_core
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_fits;

  // Partial remainder with the next dividend bit shifted in. A set carry bit
  // means the trial value exceeds any 32-bit divisor, so it always fits.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_fits  = w_shift[XLEN] | (w_shift[XLEN-1:0] >= r_dvs);
  assign w_diff  = w_shift[XLEN-1:0] - r_dvs;

  // Load operands, then one trial subtract per step.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_rem <= w_fits ? w_diff : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_fits};
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide engine. Iterative 33-cycle MULT/MULTU/DIV/DIVU,
// single-cycle MTHI/MTLO. Optional macro HILO_FAST_MULT_EN replaces the
// shift-add multiply with a single registered 32x32 multiplier.
module hilo_muldiv_unit
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  hilo_state_t        r_state;
  hilo_state_t        w_state_nxt;
  logic [ITER_W-1:0]  r_iter;
  logic [2*XLEN-1:0]  r_acc;
  logic [XLEN-1:0]    r_mcand;
  logic [XLEN-1:0]    r_a_raw;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_div0;
  logic               r_is_div;
  logic               r_busy;
  logic               r_done;
  logic [XLEN-1:0]    r_hi;
  logic [XLEN-1:0]    r_lo;

  control_t           w_op;
  logic               w_signed_op;
  logic [XLEN-1:0]    w_mag_a;
  logic [XLEN-1:0]    w_mag_b;
  logic               w_accept_mul;
  logic               w_accept_div;
  logic               w_write_lo;
  logic               w_write_hi;
  logic               w_mul_step;
  logic               w_div_step;
  logic               w_fix;
  logic [XLEN:0]      w_sum;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN-1:0]    w_quo_raw;
  logic [XLEN-1:0]    w_rem_raw;
  logic [XLEN-1:0]    w_quo;
  logic [XLEN-1:0]    w_rem;

  assign w_op        = control_t'(op);
  assign w_signed_op = (w_op == CTRL_MULT) || (w_op == CTRL_DIV);
  assign w_mag_a     = mag32(a, w_signed_op);
  assign w_mag_b     = mag32(b, w_signed_op);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-cycle datapath controls.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept_mul = 1'b0;
    w_accept_div = 1'b0;
    w_write_lo   = 1'b0;
    w_write_hi   = 1'b0;
    w_mul_step   = 1'b0;
    w_div_step   = 1'b0;
    w_fix        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (w_op)
            CTRL_MULT, CTRL_MULTU: begin
              w_accept_mul = 1'b1;
`ifdef HILO_FAST_MULT_EN
              w_state_nxt  = ST_FIX;
`else
              w_state_nxt  = ST_MUL;
`endif
            end
            CTRL_DIV, CTRL_DIVU: begin
              w_accept_div = 1'b1;
              w_state_nxt  = ST_DIV;
            end
            CTRL_MTLO: w_write_lo = 1'b1;
            CTRL_MTHI: w_write_hi = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        w_mul_step = 1'b1;
        if (r_iter == ITER_LAST) w_state_nxt = ST_FIX;
      end
      ST_DIV: begin
        w_div_step = 1'b1;
        if (r_iter == ITER_LAST) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One shift-add iteration: conditional add into the upper half, shift right.
  assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_mcand : '0)};

  // Sign fix-up of the finished results.
  assign w_prod = r_neg_res ? (~r_acc + (2*XLEN)'(1)) : r_acc;
  assign w_quo  = r_div0 ? DIV0_QUOTIENT
                         : (r_neg_res ? (~w_quo_raw + XLEN'(1)) : w_quo_raw);
  assign w_rem  = r_div0 ? r_a_raw
                         : (r_neg_rem ? (~w_rem_raw + XLEN'(1)) : w_rem_raw);

`ifdef HILO_FAST_MULT_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = (2*XLEN)'(w_mag_a) * (2*XLEN)'(w_mag_b);
`endif

  hilo_divider_core u_div (
    .clk         (clk),
    .i_rst       (reset),
    .i_load      (w_accept_div),
    .i_step      (w_div_step),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_quotient  (w_quo_raw),
    .o_remainder (w_rem_raw)
  );

  // Operand latching, iteration, HI/LO writes and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iter    <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_a_raw   <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_is_div  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_write_lo) begin
        r_lo   <= a;
        r_done <= 1'b1;
      end
      if (w_write_hi) begin
        r_hi   <= a;
        r_done <= 1'b1;
      end
      if (w_accept_mul) begin
        r_neg_res <= w_signed_op & (a[XLEN-1] ^ b[XLEN-1]);
        r_neg_rem <= 1'b0;
        r_div0    <= 1'b0;
        r_is_div  <= 1'b0;
        r_busy    <= 1'b1;
        r_iter    <= '0;
        r_mcand   <= w_mag_a;
`ifdef HILO_FAST_MULT_EN
        r_acc     <= w_fast_prod;
`else
        r_acc     <= {{XLEN{1'b0}}, w_mag_b};
`endif
      end
      if (w_accept_div) begin
        r_neg_res <= w_signed_op & (a[XLEN-1] ^ b[XLEN-1]);
        r_neg_rem <= w_signed_op & a[XLEN-1];
        r_div0    <= (b == '0);
        r_a_raw   <= a;
        r_is_div  <= 1'b1;
        r_busy    <= 1'b1;
        r_iter    <= '0;
      end
      if (w_mul_step) begin
        r_acc  <= {w_sum, r_acc[XLEN-1:1]};
        r_iter <= r_iter + ITER_W'(1);
      end
      if (w_div_step) begin
        r_iter <= r_iter + ITER_W'(1);
      end
      if (w_fix) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        if (r_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end else begin
          r_hi <= w_prod[2*XLEN-1:XLEN];
          r_lo <= w_prod[XLEN-1:0];
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit. Expected latencies follow the
// HILO_FAST_MULT_EN build setting.
module tb_hilo_muldiv_unit;

  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MTLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam int DIV_LAT = 33;
`ifdef HILO_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and count cycles after the accept edge until done.
  task automatic issue(input logic [4:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                       output int cyc);
    @(negedge clk);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin cyc = k; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mult();
    int cyc;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, cyc);
    n_checks++; if (cyc !== MUL_LAT) begin n_fail++; $display("FAIL mult_lat got %0d want %0d", cyc, MUL_LAT); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_end got %b want 0", busy); end
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, cyc);
    n_checks++; if (cyc !== MUL_LAT) begin n_fail++; $display("FAIL multu_lat got %0d want %0d", cyc, MUL_LAT); end
    n_checks++; if (hi !== 32'h2) begin n_fail++; $display("FAIL multu_hi got %h want 2", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL multu_lo got %h want fffffffa", lo); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse got %b want 0", done); end
  endtask

  task automatic test_div();
    int cyc;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    n_checks++; if (cyc !== DIV_LAT) begin n_fail++; $display("FAIL div_lat got %0d want %0d", cyc, DIV_LAT); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi); end
    issue(OP_DIVU, 32'd7, 32'd2, cyc);
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_lo got %h want 3", lo); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_hi got %h want 1", hi); end
    issue(OP_DIVU, 32'd5, 32'd0, cyc);
    n_checks++; if (cyc !== DIV_LAT) begin n_fail++; $display("FAIL divu0_lat got %0d want %0d", cyc, DIV_LAT); end
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo got %h want ffffffff", lo); end
    n_checks++; if (hi !== 32'd5) begin n_fail++; $display("FAIL divu0_hi got %h want 5", hi); end
    issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, cyc);
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo got %h want ffffffff", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL div0_hi got %h want fffffffb", hi); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL divovf_hi got %h want 0", hi); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk); start = 1'b1; op = OP_MTHI; a = 32'h1234_5678; b = 32'h0;
    @(posedge clk); #1; start = 1'b0;
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mthi_done got %b want 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %b want 0", busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_done_pulse got %b want 0", done); end
    @(negedge clk); start = 1'b1; op = OP_MTLO; a = 32'hCAFE_F00D;
    @(posedge clk); #1; start = 1'b0;
    n_checks++; if (lo !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mtlo_lo got %h want cafef00d", lo); end
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi_keep got %h want 12345678", hi); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mtlo_done got %b want 1", done); end
    // Non-HI/LO op code must be ignored.
    @(negedge clk); start = 1'b1; op = OP_ADD; a = 32'h5555_5555;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL other_op got done=%b busy=%b want 0 0", done, busy); end
    n_checks++; if (lo !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL other_op_lo got %h want cafef00d", lo); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    @(negedge clk); start = 1'b1; op = OP_MULT; a = 32'd6; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy_start got %b want 1", busy); end
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin @(negedge clk); start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF; end
      @(posedge clk); #1; start = 1'b0;
      if (k == 5) begin
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL busy_hold_hi got %h want 12345678", hi); end
        n_checks++; if (lo !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL busy_hold_lo got %h want cafef00d", lo); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid got %b want 1", busy); end
      end
      if (done === 1'b1) begin cyc = k; break; end
    end
    n_checks++; if (cyc !== MUL_LAT) begin n_fail++; $display("FAIL mul67_lat got %0d want %0d", cyc, MUL_LAT); end
    n_checks++; if (lo !== 32'd42) begin n_fail++; $display("FAIL mul67_lo got %h want 2a", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL mul67_hi got %h want 0", hi); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    longint t0;
    issue(OP_DIVU, 32'd100, 32'd7, cyc);
    t0 = $time;
    n_checks++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL b2b_first got hi=%h lo=%h want 2 e", hi, lo); end
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, cyc);
    n_checks++; if (($time - t0) !== 64'd340) begin n_fail++; $display("FAIL b2b_interval got %0d want 340", $time - t0); end
    n_checks++; if (lo !== 32'h0FFF_FFFF || hi !== 32'hF) begin n_fail++; $display("FAIL b2b_second got hi=%h lo=%h want f 0fffffff", hi, lo); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk); start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctl got busy=%b done=%b want 0 0", busy, done); end
    n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hilo got hi=%h lo=%h want 0 0", hi, lo); end
    @(negedge clk); reset = 1'b0;
    issue(OP_MULT, 32'd100, 32'hFFFF_FFFD, cyc);
    n_checks++; if (cyc !== MUL_LAT) begin n_fail++; $display("FAIL rst_mult_lat got %0d want %0d", cyc, MUL_LAT); end
    n_checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FED4) begin n_fail++; $display("FAIL rst_mult got hi=%h lo=%h want ffffffff fffffed4", hi, lo); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 5'd0; a = 32'd0; b = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
